// File: rtl/ddfs_sample_engine.sv
// Phase accumulator stepped on rising edges of div_clk, followed by a quarter-wave sine lookup.
// Optional DDFS_DITHER_EN: LFSR phase dither is added ahead of the lookup truncation.
module ddfs_sample_engine #(
  parameter int ACC_W  = 24,
  parameter int LUT_AW = 8,
  parameter int OUT_W  = 12
) (
  input  logic             clk_in,
  input  logic             arstn,
  input  logic             div_clk,
  input  logic [ACC_W-1:0] ftw_in,
  input  logic             ftw_load,
  output logic [OUT_W-1:0] sample_out,
  output logic             sample_valid,
  output logic             phase_wrap,
  output logic             ftw_busy
);
  localparam int  PH_W    = LUT_AW + 2;
  localparam int  LUT_N   = 1 << LUT_AW;
  localparam real AMP     = real'((1 << (OUT_W - 1)) - 1);
  localparam real HALF_PI = 1.5707963267948966;

  logic              div_prev_reg;
  logic              tick;
  logic [ACC_W-1:0]  acc_reg;
  logic [ACC_W-1:0]  ftw_act_reg;
  logic [ACC_W-1:0]  ftw_shd_reg;
  logic [ACC_W:0]    acc_sum;
  logic              v0_reg;
  logic              wrap0_reg;
  logic              v1_reg;
  logic              wrap1_reg;
  logic              neg_reg;
  logic [OUT_W-2:0]  mag_reg;
  logic [OUT_W-1:0]  mag_ext;
  logic [PH_W-1:0]   p;
  logic [LUT_AW-1:0] addr;
  logic [OUT_W-2:0]  rom [LUT_N];

  assign tick    = div_clk & ~div_prev_reg;
  assign acc_sum = {1'b0, acc_reg} + {1'b0, ftw_act_reg};

  // Half-LSB phase offset keeps the quadrants mirror-symmetric with no zero code.
  genvar gi;
  generate
    for (gi = 0; gi < LUT_N; gi++) begin : g_rom
      localparam int MAG = $rtoi(AMP * $sin(HALF_PI * (real'(gi) + 0.5) / real'(LUT_N)) + 0.5);
      assign rom[gi] = MAG[OUT_W-2:0];
    end
  endgenerate

`ifdef DDFS_DITHER_EN
  localparam int DW = ACC_W - LUT_AW - 2;
  localparam int DN = (DW < 16) ? DW : 16;
  logic [15:0]      lfsr_reg;
  logic [ACC_W-1:0] dith;
  logic [ACC_W-1:0] look_acc;

  always_ff @(posedge clk_in or negedge arstn) begin
    if (!arstn) begin
      lfsr_reg <= 16'hACE1;
    end else if (tick) begin
      lfsr_reg <= {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
    end
  end

  if (DN > 0) begin : g_dith
    assign dith = ACC_W'(lfsr_reg[DN-1:0]);
  end else begin : g_no_dith
    assign dith = '0;
  end

  // Dither only perturbs the lookup phase; the accumulator itself stays exact.
  assign look_acc = acc_reg + dith;
  assign p        = look_acc[ACC_W-1 -: PH_W];
`else
  assign p = acc_reg[ACC_W-1 -: PH_W];
`endif

  assign addr    = p[LUT_AW] ? ~p[LUT_AW-1:0] : p[LUT_AW-1:0];
  assign mag_ext = {1'b0, mag_reg};

  // Accumulator, tuning-word staging and tick detection.
  always_ff @(posedge clk_in or negedge arstn) begin
    if (!arstn) begin
      div_prev_reg <= 1'b0;
      acc_reg      <= '0;
      ftw_act_reg  <= '0;
      ftw_shd_reg  <= '0;
      ftw_busy     <= 1'b0;
      v0_reg       <= 1'b0;
      wrap0_reg    <= 1'b0;
    end else begin
      div_prev_reg <= div_clk;
      v0_reg       <= tick;
      if (ftw_load) begin
        ftw_shd_reg <= ftw_in;
      end
      if (tick) begin
        acc_reg     <= acc_sum[ACC_W-1:0];
        wrap0_reg   <= acc_sum[ACC_W];
        ftw_act_reg <= ftw_load ? ftw_in : ftw_shd_reg;
        ftw_busy    <= 1'b0;
      end else if (ftw_load) begin
        ftw_busy <= 1'b1;
      end
    end
  end

  // ROM data register carries no reset so it maps onto block RAM output registers.
  always_ff @(posedge clk_in) begin
    if (v0_reg) begin
      mag_reg <= rom[addr];
      neg_reg <= p[PH_W-1];
    end
  end

  always_ff @(posedge clk_in or negedge arstn) begin
    if (!arstn) begin
      v1_reg       <= 1'b0;
      wrap1_reg    <= 1'b0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      phase_wrap   <= 1'b0;
    end else begin
      v1_reg       <= v0_reg;
      wrap1_reg    <= v0_reg & wrap0_reg;
      sample_valid <= v1_reg;
      phase_wrap   <= v1_reg & wrap1_reg;
      if (v1_reg) begin
        sample_out <= neg_reg ? -mag_ext : mag_ext;
      end
    end
  end

endmodule

// File: tb/tb_ddfs_sample_engine.sv
// Bench for ddfs_sample_engine: phase/sine reference model with per-cycle compare plus directed literal checks.
module tb_ddfs_sample_engine;
  localparam real PI = 3.14159265358979323846;

  logic        clk_in;
  logic        arstn;
  logic        div_clk;
  logic [23:0] ftw_in;
  logic        ftw_load;
  logic [11:0] sample_out;
  logic        sample_valid;
  logic        phase_wrap;
  logic        ftw_busy;

  ddfs_sample_engine dut (
    .clk_in       (clk_in),
    .arstn        (arstn),
    .div_clk      (div_clk),
    .ftw_in       (ftw_in),
    .ftw_load     (ftw_load),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .phase_wrap   (phase_wrap),
    .ftw_busy     (ftw_busy)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_bad = 0;
  bit armed = 1'b0;

  typedef struct {
    int sample;
    bit wrap;
  } got_t;
  got_t got_q[$];

  // Reference state, advanced by the rules for the tuning-word registers.
  logic [23:0] acc_m  = '0;
  logic [23:0] act_m  = '0;
  logic [23:0] shd_m  = '0;
  logic [24:0] sum_m;
  bit          busy_m = 1'b0;
  bit          prev_m = 1'b0;
  bit          tk_m;
  int          cyc    = 0;
  int          exp_smp[int];
  bit          exp_wr[int];

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d", nm, act, req);
    end
  endtask

  // Full-period sine at the centre of the phase bin, rounded half away from zero.
  function automatic int sine_of(input int ph);
    real x;
    x = 2047.0 * $sin(2.0 * PI * (real'(ph) + 0.5) / 1024.0);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(-x + 0.5);
  endfunction

  function automatic int got_s(input int i);
    if (i < got_q.size()) return got_q[i].sample;
    return -99999;
  endfunction

  function automatic int got_w(input int i);
    if (i < got_q.size()) return int'(got_q[i].wrap);
    return -1;
  endfunction

  always @(posedge clk_in or negedge arstn) begin
    if (!arstn) begin
      acc_m  = '0;
      act_m  = '0;
      shd_m  = '0;
      busy_m = 1'b0;
      prev_m = 1'b0;
      exp_smp.delete();
      exp_wr.delete();
    end else begin
      cyc++;
      tk_m   = div_clk && !prev_m;
      prev_m = div_clk;
      if (tk_m) begin
        sum_m = {1'b0, acc_m} + {1'b0, act_m};
        acc_m = sum_m[23:0];
        exp_smp[cyc + 2] = sine_of(int'(acc_m[23:14]));
        exp_wr[cyc + 2]  = sum_m[24];
        act_m  = ftw_load ? ftw_in : shd_m;
        busy_m = 1'b0;
      end
      if (ftw_load) begin
        shd_m = ftw_in;
        if (!tk_m) busy_m = 1'b1;
      end
    end
  end

  always @(posedge clk_in) begin
    #1;
    if (armed) begin
      if (!arstn) begin
        chk("rst_valid", int'(sample_valid), 0);
        chk("rst_sample", int'($signed(sample_out)), 0);
        chk("rst_wrap", int'(phase_wrap), 0);
        chk("rst_busy", int'(ftw_busy), 0);
      end else begin
        if (exp_smp.exists(cyc)) begin
          chk("valid", int'(sample_valid), 1);
          chk("sample", int'($signed(sample_out)), exp_smp[cyc]);
          chk("wrap", int'(phase_wrap), int'(exp_wr[cyc]));
        end else begin
          chk("idle_valid", int'(sample_valid), 0);
        end
        chk("busy", int'(ftw_busy), int'(busy_m));
        if (sample_valid) got_q.push_back('{int'($signed(sample_out)), phase_wrap});
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic tick_once();
    @(negedge clk_in) div_clk = 1'b1;
    @(negedge clk_in) div_clk = 1'b0;
  endtask

  task automatic load_ftw(input logic [23:0] v);
    @(negedge clk_in);
    ftw_in   = v;
    ftw_load = 1'b1;
    @(negedge clk_in) ftw_load = 1'b0;
  endtask

  int base;
  int wraps;

  initial begin
    div_clk  = 1'b0;
    ftw_load = 1'b0;
    ftw_in   = '0;
    arstn    = 1'b1;
    #2;
    arstn = 1'b0;
    armed = 1'b1;

    // Reset held while div_clk toggles, then release with div_clk low.
    repeat (6) @(negedge clk_in) div_clk = ~div_clk;
    @(negedge clk_in) div_clk = 1'b0;
    idle(2);
    arstn = 1'b1;
    base = got_q.size();
    idle(6);
    chk("no_valid_after_rst", got_q.size() - base, 0);

    // Quadrant walk with FTW = quarter turn.
    load_ftw(24'h400000);
    chk("busy_after_load", int'(ftw_busy), 1);
    tick_once();
    chk("busy_after_apply", int'(ftw_busy), 0);
    idle(4);
    base = got_q.size();
    repeat (4) tick_once();
    idle(4);
    chk("quad_count", got_q.size() - base, 4);
    chk("quad_s0", got_s(base), 2047);
    chk("quad_s1", got_s(base + 1), -6);
    chk("quad_s2", got_s(base + 2), -2047);
    chk("quad_s3", got_s(base + 3), 6);
    chk("quad_w2", got_w(base + 2), 0);
    chk("quad_w3", got_w(base + 3), 1);

    // Staged load: next tick still uses the old step.
    load_ftw(24'h100000);
    chk("stage_busy", int'(ftw_busy), 1);
    base = got_q.size();
    tick_once();
    chk("stage_busy_clr", int'(ftw_busy), 0);
    tick_once();
    idle(4);
    chk("stage_count", got_q.size() - base, 2);
    chk("stage_old_step", got_s(base), 2047);

    // Load coinciding with a tick: busy never rises, new word used on next tick.
    @(negedge clk_in);
    div_clk  = 1'b1;
    ftw_load = 1'b1;
    ftw_in   = 24'h200000;
    @(negedge clk_in);
    div_clk  = 1'b0;
    ftw_load = 1'b0;
    chk("simul_busy", int'(ftw_busy), 0);
    idle(4);
    base = got_q.size();
    tick_once();
    idle(4);
    chk("simul_count", got_q.size() - base, 1);
    chk("simul_new_step", got_s(base), -6);

    // Back-to-back ticks over a full turn from acc = 0.
    @(negedge clk_in) arstn = 1'b0;
    idle(2);
    arstn = 1'b1;
    load_ftw(24'h010000);
    tick_once();
    idle(4);
    base = got_q.size();
    repeat (256) tick_once();
    idle(4);
    chk("b2b_count", got_q.size() - base, 256);
    wraps = 0;
    for (int i = base; i < got_q.size(); i++) wraps += int'(got_q[i].wrap);
    chk("b2b_wraps", wraps, 1);
    chk("b2b_wrap_at_256", got_w(base + 255), 1);
    chk("b2b_s64", got_s(base + 63), 2047);
    chk("b2b_s128", got_s(base + 127), -6);

    // Reset the cycle after a tick: that sample never appears.
    base = got_q.size();
    @(negedge clk_in) div_clk = 1'b1;
    @(negedge clk_in);
    div_clk = 1'b0;
    arstn   = 1'b0;
    idle(2);
    arstn = 1'b1;
    idle(6);
    chk("rst_mid_dropped", got_q.size() - base, 0);
    load_ftw(24'h400000);
    tick_once();
    tick_once();
    idle(4);
    chk("rst_mid_count", got_q.size() - base, 2);
    chk("rst_mid_s0", got_s(base), 6);
    chk("rst_mid_s1", got_s(base + 1), 2047);

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ddfs_sample_engine.md
# ddfs_sample_engine

Phase-accumulator and quarter-wave sine lookup stage of the DDFS datapath. It sits directly downstream of `freq_divider`: the divider's `clk_out` is the sample strobe here. Each rising edge of that strobe advances a phase accumulator by a frequency tuning word (FTW) and emits one signed sine sample. It runs entirely in the `clk_in` domain.

## Interface
- `ACC_W`, default 24: phase accumulator width.
- `LUT_AW`, default 8: quarter-wave table address width. Phase bits used = `LUT_AW+2`.
- `OUT_W`, default 12: signed sample width.
- `clk_in`  input  1  system clock, same clock that drives `freq_divider`.
- `arstn`  input  1  asynchronous, active-low reset.
- `div_clk`  input  1  divided clock from `freq_divider.clk_out`. Registered in the `clk_in` domain, so no synchronizer.
- `ftw_in`  input  ACC_W  new tuning word.
- `ftw_load`  input  1  one-cycle strobe; captures `ftw_in`.
- `sample_out`  output  OUT_W  two's-complement sine sample.
- `sample_valid`  output  1  one-cycle pulse, `sample_out` updated.
- `phase_wrap`  output  1  pulse aligned with `sample_valid`; the accumulator overflowed on that sample's update.
- `ftw_busy`  output  1  a loaded FTW is waiting in shadow and is not yet active.

## Operation
- Tick detection:
  - `div_prev` is a register of `div_clk`.
  - `tick = div_clk & ~div_prev`.
  - `div_prev` resets to 0, so a high `div_clk` on the first edge after reset counts as a tick.
- FTW handling (`ftw_shd` = shadow, `ftw_act` = active):
  - On `ftw_load`: `ftw_shd <= ftw_in`, `ftw_busy <= 1`.
  - On tick: `acc <= acc + ftw_act` (modulo 2^ACC_W), then `ftw_act <= ftw_load ? ftw_in : ftw_shd`, `ftw_busy <= 0`.
  - The tick that applies a new FTW still adds the old `ftw_act`. The new word takes effect on the following tick.
  - `ftw_load` and tick in the same cycle: both `ftw_shd` and `ftw_act` take `ftw_in`, and `ftw_busy` stays 0.
- Wrap: the carry out of the accumulator add is piped alongside the sample as `phase_wrap`.
- Lookup, using `p = acc[ACC_W-1 -: LUT_AW+2]`:
  - `q = p[LUT_AW+1:LUT_AW]`.
  - `addr = q[0] ? ~p[LUT_AW-1:0] : p[LUT_AW-1:0]`.
  - Magnitude from the ROM, negated when `q[1]=1`.
- ROM: entry i = round((2^(OUT_W-1)-1) * sin(pi/2 * (i+0.5)/2^LUT_AW)). It is generated at elaboration or held in a constant case statement, not a file. The half-LSB offset makes the four quadrants exactly symmetric, with no zero-crossing code.
- FTW = 0: the accumulator holds, and a constant sample is still emitted on every tick.

## Timing
- Pipeline for a tick seen at edge k:
  - Edge k: accumulator register updates.
  - Edge k+1: ROM read and quadrant/sign registered.
  - Edge k+2: signed `sample_out` registered; `sample_valid` and `phase_wrap` are high for that one cycle.
- Latency is 2 cycles from the accumulator update to `sample_valid`.
- The pipeline is fully pipelined. Ticks every 2 cycles (fastest `div_clk`) produce a valid pulse every 2 cycles with no loss.
- Values on reset assertion (asynchronous, immediate):
  - `acc`, `ftw_act`, `ftw_shd`, `div_prev` = 0.
  - `ftw_busy` = 0.
  - All pipeline valids = 0.
  - `sample_out` = 0, `sample_valid` = 0, `phase_wrap` = 0.
- Reset mid-pipeline discards in-flight samples; no valid pulse follows the deassertion until a new tick occurs.

## Configuration
- `DDFS_DITHER_EN` defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1 on reset) advances on each tick.
  - Its low `ACC_W-LUT_AW-2` bits (zero-extended if fewer) are added to the accumulator value before truncation into `p`, in the lookup stage. The accumulator register itself is not dithered.
  - Latency is unchanged.
- Undefined: plain truncation, no LFSR logic present.
- Test plan values below assume the macro is undefined.

## Test plan
- Reset behaviour: hold `arstn`=0 with `div_clk` toggling -> `sample_out`=0, `sample_valid`=0, `ftw_busy`=0. Release and keep `div_clk`=0 -> no `sample_valid`.
- Quadrant values (defaults): load FTW=0x400000, give one tick to activate it, then 4 ticks -> samples 2047, -6, -2047, 6. The 4th sample has `phase_wrap`=1, and each sample appears 2 cycles after its accumulator update.
- FTW staging: `ftw_load` with 0x100000 and no tick -> `ftw_busy`=1, and the next sample still uses the old step. The tick after that applies the new step and clears `ftw_busy`.
- Simultaneous `ftw_load` and tick: `ftw_busy` stays 0, and the subsequent tick adds the new FTW.
- Back-to-back ticks: `div_clk` toggling every `clk_in` cycle for 64 ticks with FTW=0x010000 -> 64 `sample_valid` pulses, no drops, and exactly one `phase_wrap` at tick 256 over a longer run of 256 ticks.
- Reset mid-operation: assert `arstn` the cycle after a tick -> no `sample_valid` for that tick. After release, the sequence restarts from `acc`=0 with `ftw_act`=0.
